// File: rtl/ebuf_wr_ptr_gen.sv
// ebuf_wr_ptr_gen: elastic-buffer write pointer, fill level and SKP-drop control; define EBUF_WR_SYNC_EN for an internal 2-flop rd_ptr_gray synchronizer
module ebuf_wr_ptr_gen #(
   parameter int ADDR_WIDTH     = 4,
   parameter int ALMOST_FULL_TH = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic                  is_skp,
   input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
   output logic                  wr_commit,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [ADDR_WIDTH:0]   wr_ptr_gray,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  full,
   output logic                  almost_full,
   output logic                  skp_dropped,
   output logic                  overflow
);
   localparam int PW = ADDR_WIDTH + 1;
   logic [PW-1:0] wr_bin, wr_bin_nxt, rd_gray_s, rd_bin;
`ifdef EBUF_WR_SYNC_EN
   logic [PW-1:0] rd_sync1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_sync1  <= '0;
         rd_gray_s <= '0;
      end else begin
         rd_sync1  <= rd_ptr_gray;
         rd_gray_s <= rd_sync1;
      end
`else
   assign rd_gray_s = rd_ptr_gray;
`endif
   always_comb begin
      rd_bin = '0;
      for (int i = 0; i < PW; i++) rd_bin[i] = ^(rd_gray_s >> i);
   end
   assign level       = wr_bin - rd_bin;
   assign full        = level == PW'(2 ** ADDR_WIDTH);
   assign almost_full = int'(level) >= ALMOST_FULL_TH;
   assign wr_commit   = wr_en & ~full & ~(is_skp & almost_full);
   assign wr_addr     = wr_bin[ADDR_WIDTH-1:0];
   assign wr_bin_nxt  = wr_bin + PW'(1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_bin      <= '0;
         wr_ptr_gray <= '0;
         skp_dropped <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         if (wr_commit) begin
            wr_bin      <= wr_bin_nxt;
            wr_ptr_gray <= wr_bin_nxt ^ (wr_bin_nxt >> 1);
         end
         skp_dropped <= wr_en & is_skp & almost_full & ~full;
         overflow    <= wr_en & full;
      end
endmodule

// File: tb/tb_ebuf_wr_ptr_gen.sv
// tb_ebuf_wr_ptr_gen: directed checks of write pointer, level, full/almost-full, SKP drop, wrap, async reset and read-pointer visibility
module tb_ebuf_wr_ptr_gen;
   logic       clk = 1'b0;
   logic       rst_n, wr_en, is_skp, wr_commit, full, almost_full, skp_dropped, overflow;
   logic [4:0] rd_ptr_gray, wr_ptr_gray, level;
   logic [3:0] wr_addr;
   int         checks = 0;
   int         errors = 0;
   int         wb;
   ebuf_wr_ptr_gen dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .is_skp(is_skp), .rd_ptr_gray(rd_ptr_gray),
      .wr_commit(wr_commit), .wr_addr(wr_addr), .wr_ptr_gray(wr_ptr_gray), .level(level),
      .full(full), .almost_full(almost_full), .skp_dropped(skp_dropped), .overflow(overflow)
   );
   always #5 clk = ~clk;
   function automatic logic [4:0] g(input int x);
      logic [4:0] b;
      b = 5'(x);
      return b ^ (b >> 1);
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic settle;
`ifdef EBUF_WR_SYNC_EN
      repeat (2) tick;
`else
      #1;
`endif
   endtask
   initial begin
      rst_n = 1'b0; wr_en = 1'b0; is_skp = 1'b0; rd_ptr_gray = '0;
      #2;
      chk("rst_ptr", wr_ptr_gray, 0);
      chk("rst_level", level, 0);
      chk("rst_full", full, 0);
      chk("rst_af", almost_full, 0);
      chk("rst_addr", wr_addr, 0);
      chk("rst_pulses", {skp_dropped, overflow}, 0);
      wr_en = 1'b1; #1;
      chk("rst_commit_follows", wr_commit, 1);
      wr_en = 1'b0; #1;
      chk("rst_commit_low", wr_commit, 0);
      tick;
      chk("rst_hold_ptr", wr_ptr_gray, 0);
      @(negedge clk) rst_n = 1'b1;
      tick;
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; #1;
         chk("basic_commit", wr_commit, 1);
         chk("basic_addr", wr_addr, i);
         tick;
         chk("basic_gray", wr_ptr_gray, (i == 0) ? 5'b00001 : (i == 1) ? 5'b00011 : 5'b00010);
      end
      chk("basic_level", level, 3);
      for (int l = 3; l < 16; l++) begin
         chk("fill_level", level, l);
         chk("fill_af", almost_full, l >= 12);
         chk("fill_full", full, 0);
         chk("fill_commit", wr_commit, 1);
         tick;
      end
      chk("full_level", level, 16);
      chk("full_flag", full, 1);
      chk("full_af", almost_full, 1);
      chk("full_gray", wr_ptr_gray, 5'b11000);
      chk("full_commit", wr_commit, 0);
      tick;
      chk("ovf_pulse", overflow, 1);
      chk("ovf_no_skp", skp_dropped, 0);
      chk("ovf_ptr_hold", wr_ptr_gray, 5'b11000);
      is_skp = 1'b1; #1;
      chk("full_skp_commit", wr_commit, 0);
      tick;
      chk("full_skp_ovf", overflow, 1);
      chk("full_skp_not_drop", skp_dropped, 0);
      wr_en = 1'b0; is_skp = 1'b0;
      tick;
      chk("ovf_clear", overflow, 0);
      rd_ptr_gray = g(4);
      settle;
      chk("skp_level12", level, 12);
      wr_en = 1'b1; is_skp = 1'b1; #1;
      chk("skp_commit", wr_commit, 0);
      tick;
      chk("skp_pulse", skp_dropped, 1);
      chk("skp_level_hold", level, 12);
      is_skp = 1'b0; #1;
      chk("nonskp_commit", wr_commit, 1);
      tick;
      chk("nonskp_level", level, 13);
      chk("skp_pulse_clear", skp_dropped, 0);
      wr_en = 1'b0;
      wb = 17;
      rd_ptr_gray = g(wb - 4);
      settle;
      chk("wrap_start_level", level, 4);
      for (int i = 0; i < 40; i++) begin
         wr_en = 1'b1; #1;
         chk("wrap_commit", wr_commit, 1);
         chk("wrap_addr", wr_addr, wb % 16);
         tick;
         wr_en = 1'b0;
         wb = (wb + 1) % 32;
         chk("wrap_gray", wr_ptr_gray, g(wb));
         if (wb == 0) chk("wrap_to_zero", wr_ptr_gray, 5'b00000);
         rd_ptr_gray = g(wb + 28);
         settle;
         chk("wrap_level", level, 4);
         chk("wrap_full", full, 0);
      end
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1;
         tick;
      end
      wr_en = 1'b1; is_skp = 1'b1;
      chk("mid_level7", level, 7);
      @(negedge clk);
      rd_ptr_gray = '0; rst_n = 1'b0; wr_en = 1'b0; is_skp = 1'b0;
      #1;
      chk("mid_rst_ptr", wr_ptr_gray, 0);
      chk("mid_rst_level", level, 0);
      chk("mid_rst_addr", wr_addr, 0);
      chk("mid_rst_pulses", {skp_dropped, overflow}, 0);
      chk("mid_rst_full", {full, almost_full}, 0);
      @(negedge clk) rst_n = 1'b1;
      tick;
      wr_en = 1'b1;
      repeat (10) tick;
      wr_en = 1'b0; #1;
      chk("sync_level10", level, 10);
      rd_ptr_gray = 5'b00011;
      #1;
`ifdef EBUF_WR_SYNC_EN
      chk("sync_edge0", level, 10);
      tick;
      chk("sync_edge1", level, 10);
      tick;
      chk("sync_edge2", level, 8);
`else
      chk("nosync_level8", level, 8);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
